pattern_rom_arbiter: RTL and testbench

Shares one synchronous pattern ROM among several channel note sequencers. Each sequencer raises a read request with an address. The arbiter grants requests one at a time in round-robin order, drives the ROM, and returns the data word with a one-cycle acknowledge. It sits between the per-channel sequencers and a single ROM instance, so the channels do not each need a private pattern table.

---
 rtl/pattern_rom_arbiter.sv | 105 ++++++++++
 tb/tb_pattern_rom_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous pattern ROM among NUM_CH sequencers.
// Each grant runs a fixed four-cycle read (IDLE, ISSUE, WAIT, ACK) ending in a one-cycle ack.
module pattern_rom_arbiter #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NUM_CH-1:0]            i_req,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] i_addr,
    output logic [NUM_CH-1:0]            o_ack,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic                         o_rom_en,
    output logic [ADDR_WIDTH-1:0]        o_rom_addr,
    input  logic [DATA_WIDTH-1:0]        i_rom_data,
    output logic                         o_busy
);

    localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [PTR_W-1:0]        r_ptr;
    logic [PTR_W-1:0]        r_gnt;
    logic [PTR_W-1:0]        w_winner;
    logic [PTR_W-1:0]        w_cand;
    logic                    w_found;
    logic                    r_rom_en;
    logic [ADDR_WIDTH-1:0]   r_rom_addr;
    logic [NUM_CH-1:0]       r_ack;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [ADDR_WIDTH-1:0]   w_addr_arr [NUM_CH];

    always_comb begin
        for (int k = 0; k < int'(NUM_CH); k++) begin
            w_addr_arr[k] = i_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // Scan from farthest to nearest so the first set bit after ptr wins last.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_ptr;
        w_cand   = r_ptr;
        for (int i = int'(NUM_CH); i >= 1; i--) begin
            w_cand = PTR_W'((int'(r_ptr) + i) % int'(NUM_CH));
            if (i_req[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_found) w_state_next = StIssue;
            StIssue: w_state_next = StWait;
            StWait:  w_state_next = StAck;
            StAck:   w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_ptr      <= PTR_W'(NUM_CH - 1);
            r_gnt      <= '0;
            r_rom_en   <= 1'b0;
            r_rom_addr <= '0;
            r_ack      <= '0;
            r_data     <= '0;
        end else begin
            r_state <= w_state_next;
            unique case (r_state)
                StIdle: begin
                    if (w_found) begin
                        r_ptr      <= w_winner;
                        r_gnt      <= w_winner;
                        r_rom_addr <= w_addr_arr[w_winner];
                        r_rom_en   <= 1'b1;
                    end
                end
                StIssue: r_rom_en <= 1'b0;
                StWait: begin
                    r_data <= i_rom_data;
                    r_ack  <= NUM_CH'(1) << r_gnt;
                end
                StAck:   r_ack <= '0;
                default: r_ack <= '0;
            endcase
        end
    end

    assign o_ack      = r_ack;
    assign o_data     = r_data;
    assign o_rom_en   = r_rom_en;
    assign o_rom_addr = r_rom_addr;
    assign o_busy     = (r_state != StIdle);

endmodule

// File: tb/tb_pattern_rom_arbiter.sv
// Bench for pattern_rom_arbiter: directed scenarios plus randomized traffic,
// all checked against a transaction-level model of grant order, timing and data.
module tb_pattern_rom_arbiter;

    localparam int NUM_CH = 4;
    localparam int AW     = 5;
    localparam int DW     = 16;

    logic               i_clk;
    logic               i_rst;
    logic [NUM_CH-1:0]  i_req;
    logic [NUM_CH*AW-1:0] i_addr;
    logic [NUM_CH-1:0]  o_ack;
    logic [DW-1:0]      o_data;
    logic               o_rom_en;
    logic [AW-1:0]      o_rom_addr;
    logic [DW-1:0]      i_rom_data;
    logic               o_busy;

    logic [AW-1:0] addr [NUM_CH];
    logic [DW-1:0] rom  [2**AW];

    int checks = 0;
    int errors = 0;

    // Model state: edge counter, pointer, last grant and when arbitration may happen next.
    int            edge_n     = 0;
    int            m_ptr      = NUM_CH - 1;
    int            m_ch       = 0;
    int            m_gnt_edge = -100;
    int            m_next_arb = 0;
    logic [DW-1:0] m_data     = '0;

    pattern_rom_arbiter #(
        .NUM_CH     (NUM_CH),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) u_dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .o_ack      (o_ack),
        .o_data     (o_data),
        .o_rom_en   (o_rom_en),
        .o_rom_addr (o_rom_addr),
        .i_rom_data (i_rom_data),
        .o_busy     (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always_comb i_addr = {addr[3], addr[2], addr[1], addr[0]};

    always @(posedge i_clk) begin
        if (o_rom_en) i_rom_data <= rom[o_rom_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_arb(input logic [NUM_CH-1:0] req, input int ptr);
        for (int i = 1; i <= NUM_CH; i++) begin
            int c;
            c = (ptr + i) % NUM_CH;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    // One clock: model arbitrates on current inputs, then outputs are checked 1 time unit after the edge.
    task automatic step();
        int w;
        logic [NUM_CH-1:0] exp_ack;
        if (!i_rst && edge_n >= m_next_arb) begin
            w = ref_arb(i_req, m_ptr);
            if (w >= 0) begin
                m_ptr      = w;
                m_ch       = w;
                m_data     = rom[addr[w]];
                m_gnt_edge = edge_n;
                m_next_arb = edge_n + 4;
            end
        end
        @(posedge i_clk);
        #1;
        if (i_rst) begin
            m_ptr      = NUM_CH - 1;
            m_gnt_edge = -100;
            m_next_arb = edge_n + 1;
            check("rst_ack", 32'(o_ack), 32'd0);
            check("rst_en", 32'(o_rom_en), 32'd0);
            check("rst_busy", 32'(o_busy), 32'd0);
        end else begin
            exp_ack = (edge_n == m_gnt_edge + 2) ? NUM_CH'(1) << m_ch : '0;
            check("m_ack", 32'(o_ack), 32'(exp_ack));
            if (exp_ack != 0) check("m_data", 32'(o_data), 32'(m_data));
            check("m_en", 32'(o_rom_en), 32'(edge_n == m_gnt_edge));
            check("m_busy", 32'(o_busy), 32'(edge_n >= m_gnt_edge && edge_n <= m_gnt_edge + 2));
        end
        edge_n++;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_req = '0;
        step();
        i_rst = 1'b0;
    endtask

    initial begin
        int n;
        int ch;
        for (int a = 0; a < 2**AW; a++) rom[a] = DW'($urandom);
        rom[5]  = 16'h1234;
        rom[31] = 16'hFFFF;
        rom[7]  = 16'hA5A5;
        rom[20] = 16'h5A5A;
        for (int c = 0; c < NUM_CH; c++) addr[c] = '0;
        i_req = '0;

        // Reset state
        do_reset();
        do_reset();
        check("rst_data", 32'(o_data), 32'd0);
        check("rst_addr", 32'(o_rom_addr), 32'd0);

        // Single read: channel 2, address 5
        i_req   = 4'b0100;
        addr[2] = 5'd5;
        step();
        check("t1_en", 32'(o_rom_en), 32'd1);
        check("t1_addr", 32'(o_rom_addr), 32'd5);
        step();
        step();
        check("t1_ack", 32'(o_ack), 32'b0100);
        check("t1_data", 32'(o_data), 32'h1234);
        i_req = '0;
        step();
        check("t1_busy", 32'(o_busy), 32'd0);

        // Simultaneous requests from all channels after reset
        do_reset();
        for (int c = 0; c < NUM_CH; c++) addr[c] = AW'(c + 1);
        i_req = 4'b1111;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k % 4 == 3) begin
                check("t2_ack", 32'(o_ack), 32'(1) << (k / 4));
                check("t2_data", 32'(o_data), 32'(rom[k / 4 + 1]));
                i_req[k / 4] = 1'b0;
            end
        end

        // Fairness: channels 0 and 3 hold requests continuously
        do_reset();
        addr[0] = AW'($urandom);
        addr[3] = AW'($urandom);
        i_req = 4'b1001;
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (o_ack != 0) begin
                ch = -1;
                for (int c = 0; c < NUM_CH; c++) if (o_ack[c]) ch = c;
                check("t3_alt", 32'(ch), (n % 2 == 0) ? 32'd0 : 32'd3);
                n++;
            end
        end
        check("t3_count", 32'(n), 32'd10);
        i_req = '0;
        step();

        // Late drop and address change after grant
        do_reset();
        i_req   = 4'b0010;
        addr[1] = 5'd7;
        step();
        check("t4_addr", 32'(o_rom_addr), 32'd7);
        step();
        i_req   = '0;
        addr[1] = 5'd20;
        step();
        check("t4_ack", 32'(o_ack), 32'b0010);
        check("t4_data", 32'(o_data), 32'hA5A5);
        step();

        // Reset landing in the WAIT cycle
        i_req = 4'b0110;
        step();
        step();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        check("t5_ack", 32'(o_ack), 32'd0);
        check("t5_en", 32'(o_rom_en), 32'd0);
        check("t5_busy", 32'(o_busy), 32'd0);
        i_req = 4'b0111;
        step();
        step();
        step();
        check("t5_first", 32'(o_ack), 32'b0001);
        i_req = '0;
        step();

        // Address boundary: channel 3 reads the top word
        do_reset();
        i_req   = 4'b1000;
        addr[3] = 5'd31;
        step();
        check("t6_addr", 32'(o_rom_addr), 32'd31);
        step();
        step();
        check("t6_ack", 32'(o_ack), 32'b1000);
        check("t6_data", 32'(o_data), 32'hFFFF);
        i_req = '0;
        step();

        // Randomized traffic; requests held until acked
        do_reset();
        for (int k = 0; k < 600; k++) begin
            step();
            for (int c = 0; c < NUM_CH; c++) begin
                if (o_ack[c]) begin
                    if ($urandom_range(1) == 0) i_req[c] = 1'b0;
                    else addr[c] = AW'($urandom);
                end else if (!i_req[c] && $urandom_range(3) == 0) begin
                    i_req[c] = 1'b1;
                    addr[c]  = AW'($urandom);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
